mdu_iter: RTL and testbench

MDU_ITER -- requirements
Module: mdu_iter

---
 rtl/mdu_iter.sv | 296 +++++++++++++++++++++++++++++
 tb/tb_mdu_iter.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_iter.sv
// -----------------------------------------------------------------------------
// mdu_iter -- iterative multiply / divide unit.
//
// One operation at a time. Multiplies are shift-add (one multiplier bit per
// cycle into a 2*XLEN accumulator); divides are restoring (one quotient bit per
// cycle). Signed operands are reduced to magnitudes up front and the result
// sign is applied once, on the last iteration. Divide-by-zero and the signed
// overflow case (most-negative / -1) are resolved at issue and skip iteration.
//
// Ports
//   clk, rst        clock, asynchronous active-high reset
//   i_vld / o_rdy   issue handshake (o_rdy only while idle)
//   i_micop         operation code (mul..remuw, 0x08..0x13)
//   i_src0/i_src1   multiplicand|dividend / multiplier|divisor
//   i_tag           opaque destination tag, returned with the result
//   i_flush         kills whatever is in flight, blocks a same-cycle issue
//   o_vld/i_wb_rdy  writeback handshake; result and tag held until taken
//   o_result/o_tag  writeback data and tag
//
// XLEN must be greater than 32 (the W forms work on the low 32 bits).
// -----------------------------------------------------------------------------
module mdu_iter #(
  parameter int XLEN  = 64,
  parameter int TAG_W = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_vld,
  output logic             o_rdy,
  input  logic [4:0]       i_micop,
  input  logic [XLEN-1:0]  i_src0,
  input  logic [XLEN-1:0]  i_src1,
  input  logic [TAG_W-1:0] i_tag,
  input  logic             i_flush,
  output logic             o_vld,
  input  logic             i_wb_rdy,
  output logic [XLEN-1:0]  o_result,
  output logic [TAG_W-1:0] o_tag
);

  // Operation encodings.
  localparam logic [4:0] OP_MUL    = 5'h08;
  localparam logic [4:0] OP_MULW   = 5'h09;
  localparam logic [4:0] OP_MULH   = 5'h0A;
  localparam logic [4:0] OP_MULHU  = 5'h0B;
  localparam logic [4:0] OP_MULHSU = 5'h0C;
  localparam logic [4:0] OP_DIV    = 5'h0D;
  localparam logic [4:0] OP_DIVW   = 5'h0E;
  localparam logic [4:0] OP_DIVU   = 5'h0F;
  localparam logic [4:0] OP_REM    = 5'h10;
  localparam logic [4:0] OP_REMW   = 5'h11;
  localparam logic [4:0] OP_REMU   = 5'h12;
  localparam logic [4:0] OP_REMUW  = 5'h13;

  // FSM states.
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam int              CNT_W  = $clog2(XLEN + 1);
  localparam logic [CNT_W-1:0] N_FULL = CNT_W'(XLEN);
  localparam logic [CNT_W-1:0] N_WORD = CNT_W'(32);

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  function automatic logic [XLEN-1:0] f_sext32(input logic [31:0] v);
    return {{(XLEN-32){v[31]}}, v};
  endfunction

  // Picks the architectural result out of the signed product / quotient /
  // remainder. Unlisted opcodes fall through to zero.
  function automatic logic [XLEN-1:0] f_format(
    input logic [4:0]        op,
    input logic [2*XLEN-1:0] prod,
    input logic [XLEN-1:0]   quo,
    input logic [XLEN-1:0]   rem
  );
    logic [XLEN-1:0] res;
    res = '0;
    case (op)
      OP_MUL:                        res = prod[XLEN-1:0];
      OP_MULW:                       res = f_sext32(prod[31:0]);
      OP_MULH, OP_MULHU, OP_MULHSU:  res = prod[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:               res = quo;
      OP_DIVW:                       res = f_sext32(quo[31:0]);
      OP_REM, OP_REMU:               res = rem;
      OP_REMW, OP_REMUW:             res = f_sext32(rem[31:0]);
      default:                       res = '0;
    endcase
    return res;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [1:0]          r_state;
  logic [4:0]          r_op;
  logic [TAG_W-1:0]    r_tag;
  logic                r_is_div;
  logic                r_neg_q;    // sign of product or quotient
  logic                r_neg_r;    // sign of remainder
  logic [CNT_W-1:0]    r_cnt;      // iterations left in CALC
  logic [2*XLEN-1:0]   r_acc;      // product accumulator
  logic [2*XLEN-1:0]   r_mcand;    // multiplicand, shifts left each step
  logic [XLEN-1:0]     r_b;        // multiplier (shifts right) or dividend/quotient (shifts left)
  logic [XLEN-1:0]     r_rem;      // partial remainder
  logic [XLEN-1:0]     r_dvsr;     // divisor magnitude
  logic [XLEN-1:0]     r_result;

  // ---------------------------------------------------------------------------
  // Issue-side decode and operand preparation (from the request inputs)
  // ---------------------------------------------------------------------------
  logic            w_accept;
  logic            w_is_w;
  logic            w_is_div;
  logic            w_sgn0;
  logic            w_sgn1;
  logic [XLEN-1:0] w_ext0;
  logic [XLEN-1:0] w_ext1;
  logic            w_neg0;
  logic            w_neg1;
  logic [XLEN-1:0] w_mag0;
  logic [XLEN-1:0] w_mag1;
  logic            w_is_min0;
  logic            w_div_zero;
  logic            w_div_ovf;
  logic [XLEN-1:0] w_spec_result;

  assign w_accept = i_vld && o_rdy && !i_flush;

  assign w_is_w   = (i_micop == OP_MULW) || (i_micop == OP_DIVW) ||
                    (i_micop == OP_REMW) || (i_micop == OP_REMUW);
  assign w_is_div = i_micop inside {[OP_DIV:OP_REMUW]};
  // mul/mulw need no sign handling: the low product bits are sign-agnostic.
  assign w_sgn0   = i_micop inside {OP_MULH, OP_MULHSU, OP_DIV, OP_DIVW, OP_REM, OP_REMW};
  assign w_sgn1   = i_micop inside {OP_MULH, OP_DIV, OP_DIVW, OP_REM, OP_REMW};

  // NOTE: every signal driven in an always_comb gets a value on every path
  // (here by a default first), otherwise synthesis infers a latch.
  always_comb begin
    w_ext0 = i_src0;
    w_ext1 = i_src1;
    if (w_is_w) begin
      if (i_micop == OP_REMUW) begin
        w_ext0 = {{(XLEN-32){1'b0}}, i_src0[31:0]};
        w_ext1 = {{(XLEN-32){1'b0}}, i_src1[31:0]};
      end else begin
        w_ext0 = f_sext32(i_src0[31:0]);
        w_ext1 = f_sext32(i_src1[31:0]);
      end
    end
  end

  assign w_neg0 = w_sgn0 && w_ext0[XLEN-1];
  assign w_neg1 = w_sgn1 && w_ext1[XLEN-1];
  assign w_mag0 = w_neg0 ? -w_ext0 : w_ext0;
  assign w_mag1 = w_neg1 ? -w_ext1 : w_ext1;

  // W operands are already sign-extended, so only the low word needs checking.
  assign w_is_min0  = w_is_w ? (w_ext0[31:0] == 32'h8000_0000)
                             : (w_ext0 == {1'b1, {(XLEN-1){1'b0}}});
  assign w_div_zero = w_is_div && (w_ext1 == '0);
  assign w_div_ovf  = w_is_div && w_sgn1 && w_is_min0 && (w_ext1 == '1);

  // Special divides: zero divisor -> q = all ones, r = dividend;
  // overflow -> q = dividend, r = 0.
  assign w_spec_result = f_format(i_micop, '0,
                                  w_div_zero ? '1 : w_ext0,
                                  w_div_zero ? w_ext0 : '0);

  // ---------------------------------------------------------------------------
  // One iteration step (from the registered datapath)
  // ---------------------------------------------------------------------------
  logic [2*XLEN-1:0] w_acc_nxt;
  logic [2*XLEN-1:0] w_mcand_nxt;
  logic [XLEN-1:0]   w_b_nxt;
  logic [XLEN-1:0]   w_rem_nxt;
  logic [XLEN:0]     w_rem_sh;
  logic [XLEN-1:0]   w_diff;
  logic              w_ge;

  // Restoring divide: bring down the next dividend bit and subtract if it fits.
  // When it fits the true difference is below 2^XLEN, so the modular XLEN-bit
  // subtraction is exact.
  assign w_rem_sh = {r_rem, r_b[XLEN-1]};
  assign w_ge     = (w_rem_sh >= {1'b0, r_dvsr});
  assign w_diff   = w_rem_sh[XLEN-1:0] - r_dvsr;

  always_comb begin
    w_acc_nxt   = r_acc;
    w_mcand_nxt = r_mcand;
    w_b_nxt     = r_b;
    w_rem_nxt   = r_rem;
    if (r_is_div) begin
      w_rem_nxt = w_ge ? w_diff : w_rem_sh[XLEN-1:0];
      w_b_nxt   = {r_b[XLEN-2:0], w_ge};
    end else begin
      if (r_b[0]) w_acc_nxt = r_acc + r_mcand;
      w_mcand_nxt = {r_mcand[2*XLEN-2:0], 1'b0};
      w_b_nxt     = {1'b0, r_b[XLEN-1:1]};
    end
  end

  // Result of the final step, signs applied.
  logic [2*XLEN-1:0] w_prod_fin;
  logic [XLEN-1:0]   w_quo_fin;
  logic [XLEN-1:0]   w_rem_fin;
  logic [XLEN-1:0]   w_calc_result;

  assign w_prod_fin    = r_neg_q ? -w_acc_nxt : w_acc_nxt;
  assign w_quo_fin     = r_neg_q ? -w_b_nxt   : w_b_nxt;
  assign w_rem_fin     = r_neg_r ? -w_rem_nxt : w_rem_nxt;
  assign w_calc_result = f_format(r_op, w_prod_fin, w_quo_fin, w_rem_fin);

  // ---------------------------------------------------------------------------
  // FSM and datapath registers
  // ---------------------------------------------------------------------------
  // NOTE: state updates use non-blocking assignments so every register samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the datapath is cleared too, not just the FSM, so o_result/o_tag
      // read zero out of reset and no stale operand survives an abort.
      r_state  <= S_IDLE;
      r_op     <= '0;
      r_tag    <= '0;
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_b      <= '0;
      r_rem    <= '0;
      r_dvsr   <= '0;
      r_result <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_op     <= i_micop;
            r_tag    <= i_tag;
            r_is_div <= w_is_div;
            r_neg_q  <= w_neg0 ^ w_neg1;
            r_neg_r  <= w_neg0;
            r_cnt    <= w_is_w ? N_WORD : N_FULL;
            r_acc    <= '0;
            r_mcand  <= {{XLEN{1'b0}}, w_mag0};
            r_rem    <= '0;
            r_dvsr   <= w_mag1;
            // A W dividend is left-aligned so its bit 31 is brought down first.
            if (w_is_div)
              r_b <= w_is_w ? (w_mag0 << (XLEN - 32)) : w_mag0;
            else
              r_b <= w_mag1;
            if (w_div_zero || w_div_ovf) begin
              r_result <= w_spec_result;
              r_state  <= S_DONE;
            end else begin
              r_state  <= S_CALC;
            end
          end
        end

        S_CALC: begin
          if (i_flush) begin
            r_state <= S_IDLE;
          end else begin
            r_acc   <= w_acc_nxt;
            r_mcand <= w_mcand_nxt;
            r_b     <= w_b_nxt;
            r_rem   <= w_rem_nxt;
            r_cnt   <= r_cnt - 1'b1;
            if (r_cnt == CNT_W'(1)) begin
              r_result <= w_calc_result;
              r_state  <= S_DONE;
            end
          end
        end

        S_DONE: begin
          if (i_flush || i_wb_rdy) r_state <= S_IDLE;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_rdy    = (r_state == S_IDLE);
  assign o_vld    = (r_state == S_DONE);
  assign o_result = r_result;
  assign o_tag    = r_tag;

endmodule

// File: tb/tb_mdu_iter.sv
// -----------------------------------------------------------------------------
// tb_mdu_iter -- directed self-checking bench for mdu_iter.
// Inputs change and outputs are sampled 1 ns after each rising edge.
// -----------------------------------------------------------------------------
module tb_mdu_iter;

  localparam int XLEN  = 64;
  localparam int TAG_W = 7;

  localparam logic [4:0] OP_MUL    = 5'h08;
  localparam logic [4:0] OP_MULW   = 5'h09;
  localparam logic [4:0] OP_MULH   = 5'h0A;
  localparam logic [4:0] OP_MULHU  = 5'h0B;
  localparam logic [4:0] OP_MULHSU = 5'h0C;
  localparam logic [4:0] OP_DIV    = 5'h0D;
  localparam logic [4:0] OP_DIVW   = 5'h0E;
  localparam logic [4:0] OP_DIVU   = 5'h0F;
  localparam logic [4:0] OP_REM    = 5'h10;
  localparam logic [4:0] OP_REMW   = 5'h11;
  localparam logic [4:0] OP_REMU   = 5'h12;
  localparam logic [4:0] OP_REMUW  = 5'h13;

  logic             clk = 1'b0;
  logic             rst;
  logic             i_vld;
  logic             o_rdy;
  logic [4:0]       i_micop;
  logic [XLEN-1:0]  i_src0;
  logic [XLEN-1:0]  i_src1;
  logic [TAG_W-1:0] i_tag;
  logic             i_flush;
  logic             o_vld;
  logic             i_wb_rdy;
  logic [XLEN-1:0]  o_result;
  logic [TAG_W-1:0] o_tag;

  int n_checks = 0;
  int n_fail   = 0;

  mdu_iter #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .i_vld    (i_vld),
    .o_rdy    (o_rdy),
    .i_micop  (i_micop),
    .i_src0   (i_src0),
    .i_src1   (i_src1),
    .i_tag    (i_tag),
    .i_flush  (i_flush),
    .o_vld    (o_vld),
    .i_wb_rdy (i_wb_rdy),
    .o_result (o_result),
    .o_tag    (o_tag)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish (checks=%0d failures=%0d)", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

  typedef struct packed {
    logic [4:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] exp;
    logic [7:0]  lat;
  } vec_t;

  // ---------------------------------------------------------------------------
  // Stimulus helpers (no checking here)
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one request for a single cycle; returns 1 ns after that edge.
  task automatic issue(input logic [4:0] op, input logic [63:0] a, input logic [63:0] b,
                       input logic [TAG_W-1:0] tag);
    i_vld   = 1'b1;
    i_micop = op;
    i_src0  = a;
    i_src1  = b;
    i_tag   = tag;
    tick();
    i_vld   = 1'b0;
    i_micop = '0;
    i_src0  = '0;
    i_src1  = '0;
    i_tag   = '0;
  endtask

  // lat = number of edges from the accept edge to the first o_vld (bounded).
  task automatic wait_vld(output int lat);
    lat = 1;
    while (!o_vld && lat < 200) begin
      tick();
      lat++;
    end
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst      = 1'b1;
    i_vld    = 1'b0;
    i_micop  = '0;
    i_src0   = '0;
    i_src1   = '0;
    i_tag    = '0;
    i_flush  = 1'b0;
    i_wb_rdy = 1'b1;
    repeat (3) tick();
    n_checks++;
    if (o_vld !== 1'b0) begin n_fail++; $display("FAIL reset_o_vld got=%b exp=0", o_vld); end
    n_checks++;
    if (o_rdy !== 1'b1) begin n_fail++; $display("FAIL reset_o_rdy got=%b exp=1", o_rdy); end
    n_checks++;
    if (o_result !== '0) begin n_fail++; $display("FAIL reset_o_result got=%h exp=0", o_result); end
    n_checks++;
    if (o_tag !== '0) begin n_fail++; $display("FAIL reset_o_tag got=%h exp=0", o_tag); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_mul_basic();
    int lat;
    issue(OP_MUL, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 7'h15);
    wait_vld(lat);
    n_checks++;
    if (lat != 65) begin n_fail++; $display("FAIL mul_latency got=%0d exp=65", lat); end
    n_checks++;
    if (o_result !== 64'hFFFF_FFFF_FFFF_FFEB) begin
      n_fail++; $display("FAIL mul_result got=%h exp=ffffffffffffffeb", o_result);
    end
    n_checks++;
    if (o_tag !== 7'h15) begin n_fail++; $display("FAIL mul_tag got=%h exp=15", o_tag); end
    tick();  // handshake with i_wb_rdy=1
    n_checks++;
    if (o_vld !== 1'b0 || o_rdy !== 1'b1) begin
      n_fail++; $display("FAIL mul_handshake got vld=%b rdy=%b exp vld=0 rdy=1", o_vld, o_rdy);
    end
  endtask

  task automatic test_arith();
    vec_t vecs[$];
    int   lat;
    // Special-case divides (skip CALC)
    vecs.push_back('{OP_DIV,   64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 8'd1});
    vecs.push_back('{OP_REM,   64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 8'd1});
    vecs.push_back('{OP_DIVU,  64'd100, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 8'd1});
    vecs.push_back('{OP_REMU,  64'd100, 64'd0, 64'd100, 8'd1});
    vecs.push_back('{OP_DIVW,  64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 8'd1});
    vecs.push_back('{OP_REMUW, 64'h1234_5678_9ABC_DEF0, 64'hFFFF_FFFF_0000_0000, 64'hFFFF_FFFF_9ABC_DEF0, 8'd1});
    // W ops (32 iterations)
    vecs.push_back('{OP_REMW,  64'h0000_0000_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 8'd33});
    vecs.push_back('{OP_DIVW,  64'h0000_0000_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 8'd33});
    vecs.push_back('{OP_MULW,  64'hFFFF_FFFF_0000_0003, 64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFD, 8'd33});
    // Full-width ops (64 iterations)
    vecs.push_back('{OP_MULHU, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, 8'd65});
    vecs.push_back('{OP_MULH,  64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'h4000_0000_0000_0000, 8'd65});
    vecs.push_back('{OP_MULHSU,64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 8'd65});
    vecs.push_back('{OP_MUL,   64'h0000_0001_0000_0001, 64'h0000_0001_0000_0001, 64'h0000_0002_0000_0001, 8'd65});
    vecs.push_back('{OP_DIV,   64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 8'd65});
    vecs.push_back('{OP_REM,   64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 8'd65});
    vecs.push_back('{OP_DIV,   64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFD, 8'd65});
    vecs.push_back('{OP_REM,   64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'd1, 8'd65});
    vecs.push_back('{OP_DIVU,  64'd1000, 64'd7, 64'd142, 8'd65});
    vecs.push_back('{OP_REMU,  64'd1000, 64'd7, 64'd6, 8'd65});
    vecs.push_back('{OP_DIVU,  64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0001_0000_0000, 64'h0000_0000_FFFF_FFFF, 8'd65});
    // Unlisted opcodes complete normally with zero
    vecs.push_back('{5'h1F,    64'd5, 64'd6, 64'd0, 8'd65});
    vecs.push_back('{5'h00,    64'd5, 64'd6, 64'd0, 8'd65});

    foreach (vecs[i]) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b, TAG_W'(i + 1));
      wait_vld(lat);
      n_checks++;
      if (lat != int'(vecs[i].lat)) begin
        n_fail++; $display("FAIL arith[%0d]_latency op=%h got=%0d exp=%0d", i, vecs[i].op, lat, vecs[i].lat);
      end
      n_checks++;
      if (o_result !== vecs[i].exp) begin
        n_fail++; $display("FAIL arith[%0d]_result op=%h got=%h exp=%h", i, vecs[i].op, o_result, vecs[i].exp);
      end
      n_checks++;
      if (o_tag !== TAG_W'(i + 1)) begin
        n_fail++; $display("FAIL arith[%0d]_tag got=%h exp=%h", i, o_tag, TAG_W'(i + 1));
      end
      tick();
      if (!o_rdy) begin
        rst = 1'b1; tick(); rst = 1'b0; tick();
      end
    end
  endtask

  task automatic test_flush();
    int   lat;
    logic seen;
    // Flush mid-CALC: divu 1000/7, flush during cycle T+10.
    seen = 1'b0;
    issue(OP_DIVU, 64'd1000, 64'd7, 7'h03);          // now in cycle T+1
    repeat (9) begin
      if (o_vld) seen = 1'b1;
      tick();
    end                                              // now in cycle T+10
    if (o_vld) seen = 1'b1;
    i_flush = 1'b1;
    tick();                                          // now in cycle T+11
    i_flush = 1'b0;
    n_checks++;
    if (seen !== 1'b0 || o_vld !== 1'b0) begin
      n_fail++; $display("FAIL flush_calc_no_vld got seen=%b vld=%b exp 0", seen, o_vld);
    end
    n_checks++;
    if (o_rdy !== 1'b1) begin n_fail++; $display("FAIL flush_calc_rdy got=%b exp=1", o_rdy); end
    issue(OP_MUL, 64'd3, 64'd4, 7'h04);              // accepted at end of T+11
    wait_vld(lat);
    n_checks++;
    if (lat != 65) begin n_fail++; $display("FAIL flush_next_latency got=%0d exp=65", lat); end
    n_checks++;
    if (o_result !== 64'd12 || o_tag !== 7'h04) begin
      n_fail++; $display("FAIL flush_next_result got=%h/%h exp=c/04", o_result, o_tag);
    end
    tick();

    // Flush together with an issue in IDLE: not accepted.
    i_vld   = 1'b1; i_micop = OP_MUL; i_src0 = 64'd3; i_src1 = 64'd4; i_tag = 7'h05;
    i_flush = 1'b1;
    tick();
    i_vld = 1'b0; i_flush = 1'b0;
    n_checks++;
    if (o_rdy !== 1'b1) begin n_fail++; $display("FAIL flush_idle_rdy got=%b exp=1", o_rdy); end
    seen = 1'b0;
    repeat (70) begin
      if (o_vld) seen = 1'b1;
      tick();
    end
    n_checks++;
    if (seen !== 1'b0) begin n_fail++; $display("FAIL flush_idle_no_vld got=%b exp=0", seen); end

    // Flush in DONE while the result is being held.
    i_wb_rdy = 1'b0;
    issue(OP_DIVU, 64'd100, 64'd0, 7'h06);
    wait_vld(lat);
    n_checks++;
    if (lat != 1 || o_vld !== 1'b1) begin
      n_fail++; $display("FAIL flush_done_setup got lat=%0d vld=%b exp lat=1 vld=1", lat, o_vld);
    end
    i_flush = 1'b1;
    tick();
    i_flush = 1'b0;
    n_checks++;
    if (o_vld !== 1'b0 || o_rdy !== 1'b1) begin
      n_fail++; $display("FAIL flush_done got vld=%b rdy=%b exp vld=0 rdy=1", o_vld, o_rdy);
    end
    i_wb_rdy = 1'b1;
    tick();
  endtask

  task automatic test_back_to_back();
    int lat;
    logic ok;
    // mulw with writeback stalled for 5 cycles.
    i_wb_rdy = 1'b0;
    issue(OP_MULW, 64'h0000_0000_7FFF_FFFF, 64'd2, 7'h2A);
    wait_vld(lat);
    n_checks++;
    if (lat != 33) begin n_fail++; $display("FAIL bp_latency got=%0d exp=33", lat); end
    n_checks++;
    if (o_result !== 64'hFFFF_FFFF_FFFF_FFFE) begin
      n_fail++; $display("FAIL bp_result got=%h exp=fffffffffffffffe", o_result);
    end
    ok = 1'b1;
    repeat (5) begin
      tick();
      if (o_vld !== 1'b1 || o_rdy !== 1'b0 || o_result !== 64'hFFFF_FFFF_FFFF_FFFE || o_tag !== 7'h2A)
        ok = 1'b0;
    end
    n_checks++;
    if (ok !== 1'b1) begin
      n_fail++; $display("FAIL bp_hold got vld=%b rdy=%b res=%h tag=%h", o_vld, o_rdy, o_result, o_tag);
    end
    // Release writeback with a new request already waiting: the request must
    // not be taken in the handshake cycle, only in the next one.
    i_wb_rdy = 1'b1;
    i_vld = 1'b1; i_micop = OP_MUL; i_src0 = 64'd3; i_src1 = 64'd4; i_tag = 7'h2B;
    tick();
    n_checks++;
    if (o_vld !== 1'b0 || o_rdy !== 1'b1) begin
      n_fail++; $display("FAIL b2b_no_accept_on_handshake got vld=%b rdy=%b exp vld=0 rdy=1", o_vld, o_rdy);
    end
    tick();
    i_vld = 1'b0; i_micop = '0; i_src0 = '0; i_src1 = '0; i_tag = '0;
    n_checks++;
    if (o_rdy !== 1'b0) begin n_fail++; $display("FAIL b2b_accept got rdy=%b exp=0", o_rdy); end
    wait_vld(lat);
    n_checks++;
    if (lat != 65 || o_result !== 64'd12 || o_tag !== 7'h2B) begin
      n_fail++; $display("FAIL b2b_result got lat=%0d res=%h tag=%h exp lat=65 res=c tag=2b", lat, o_result, o_tag);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    int   lat;
    logic seen;
    // Reset during CALC.
    issue(OP_MUL, 64'd9, 64'd9, 7'h11);
    repeat (10) tick();
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (o_rdy !== 1'b1 || o_vld !== 1'b0 || o_tag !== '0) begin
      n_fail++; $display("FAIL rst_calc_async got rdy=%b vld=%b tag=%h exp rdy=1 vld=0 tag=0", o_rdy, o_vld, o_tag);
    end
    tick();
    rst = 1'b0;
    seen = 1'b0;
    repeat (80) begin
      if (o_vld) seen = 1'b1;
      tick();
    end
    n_checks++;
    if (seen !== 1'b0) begin n_fail++; $display("FAIL rst_calc_no_vld got=%b exp=0", seen); end

    // Reset while a result is held in DONE.
    i_wb_rdy = 1'b0;
    issue(OP_DIVU, 64'd100, 64'd0, 7'h12);
    wait_vld(lat);
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (o_vld !== 1'b0 || o_result !== '0) begin
      n_fail++; $display("FAIL rst_done_async got vld=%b res=%h exp vld=0 res=0", o_vld, o_result);
    end
    tick();
    rst = 1'b0;
    seen = 1'b0;
    repeat (10) begin
      if (o_vld) seen = 1'b1;
      tick();
    end
    n_checks++;
    if (seen !== 1'b0) begin n_fail++; $display("FAIL rst_done_no_vld got=%b exp=0", seen); end
    i_wb_rdy = 1'b1;
  endtask

  initial begin
    test_reset();
    test_mul_basic();
    test_arith();
    test_flush();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
